dvi_frame_checker: RTL and testbench

Sink-side monitor for the DVI pixel/sync stream produced by the stimulus generator. It consumes red/green/blue/hsync/vsync on the pixel clock, measures active pixels per line and lines per frame, and checks every active pixel against the expected test pattern. It latches a pass/fail verdict plus diagnostic counters at end of frame, so benches and on-chip debug can confirm the generator output before it reaches the TMDS encoder.

---
 rtl/dvi_frame_checker.sv | 149 ++++++++++++++
 tb/tb_dvi_frame_checker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_frame_checker.sv
// Purpose: sink-side checker for the DVI pixel/sync stream: counts pixels per line and lines per frame, checks each pixel against a fixed pattern.
// Latency: counters and flags update the cycle after a pixel or sync edge is sampled; done/pass appear the cycle after the vsync rise.
// Backpressure: none. The stream is consumed every clock and the checker never stalls the source.
module dvi_frame_checker #(
   parameter int          WIDTH     = 1280,
   parameter int          HEIGHT    = 720,
   parameter logic [23:0] FIRST_RGB = 24'h0000FF,
   parameter logic [23:0] REST_RGB  = 24'hFF00FF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  red,
   input  logic [7:0]  green,
   input  logic [7:0]  blue,
   input  logic        hsync,
   input  logic        vsync,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        err_width,
   output logic        err_height,
   output logic [9:0]  line_count,
   output logic [10:0] last_width,
   output logic [15:0] err_count
);

   localparam logic [10:0] WIDTH_L  = 11'(WIDTH);
   localparam logic [9:0]  HEIGHT_L = 10'(HEIGHT);

   typedef enum logic [1:0] {IDLE, WAIT_SYNC, LINE, DONE} state_t;

   state_t      state;
   logic        hsync_d;
   logic        vsync_d;
   logic [10:0] pix_cnt;

   logic        hs_rise;
   logic        vs_rise;
   logic        pix_vld;
   logic        mismatch;
   logic [23:0] exp_rgb;
   logic [9:0]  lines_next;
   logic [10:0] pix_next;
   logic [15:0] errs_next;
   logic        width_bad;

   // Edge detection, pixel qualification and the saturating next values used when a line closes.
   always_comb begin
      hs_rise    = hsync & ~hsync_d;
      vs_rise    = vsync & ~vsync_d;
      pix_vld    = (state == LINE) & ~hsync & ~vsync;
      exp_rgb    = (pix_cnt == 11'd0) ? FIRST_RGB : REST_RGB;
      // Pixels past the expected width are counted but never pattern-checked.
      mismatch   = pix_vld & (pix_cnt < WIDTH_L) & ({red, green, blue} != exp_rgb);
      lines_next = (line_count == 10'h3FF) ? line_count : line_count + 10'd1;
      pix_next   = (pix_cnt == 11'h7FF) ? pix_cnt : pix_cnt + 11'd1;
      errs_next  = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
      width_bad  = (pix_cnt != WIDTH_L);
   end

   // Sync history, kept running in every state so edges are seen right after arming.
   always_ff @(posedge clock) begin
      if (reset) begin
         hsync_d <= 1'b0;
         vsync_d <= 1'b0;
      end else begin
         hsync_d <= hsync;
         vsync_d <= vsync;
      end
   end

   // Frame state machine with registered status outputs and statistics.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_width  <= 1'b0;
         err_height <= 1'b0;
         line_count <= 10'd0;
         last_width <= 11'd0;
         err_count  <= 16'd0;
         pix_cnt    <= 11'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= WAIT_SYNC;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_width  <= 1'b0;
                  err_height <= 1'b0;
                  line_count <= 10'd0;
                  last_width <= 11'd0;
                  err_count  <= 16'd0;
                  pix_cnt    <= 11'd0;
               end
            end
            WAIT_SYNC: begin
               // A frame end before any line is a zero-line frame.
               if (vs_rise) begin
                  state      <= DONE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  pass       <= 1'b0;
                  err_height <= 1'b1;
               end else if (hs_rise) begin
                  state   <= LINE;
                  pix_cnt <= 11'd0;
               end
            end
            LINE: begin
               if (vs_rise) begin
                  // Close the open line and finish; a coincident hsync rise opens nothing.
                  last_width <= pix_cnt;
                  err_width  <= err_width | width_bad;
                  line_count <= lines_next;
                  pix_cnt    <= 11'd0;
                  err_height <= err_height | (lines_next != HEIGHT_L);
                  pass       <= ~(err_width | width_bad) & ~err_height &
                                (lines_next == HEIGHT_L) & (err_count == 16'd0);
                  state      <= DONE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
               end else if (hs_rise) begin
                  last_width <= pix_cnt;
                  err_width  <= err_width | width_bad;
                  line_count <= lines_next;
                  pix_cnt    <= 11'd0;
               end else if (pix_vld) begin
                  pix_cnt <= pix_next;
                  if (mismatch) begin
                     err_count <= errs_next;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dvi_frame_checker.sv
// Purpose: scoreboard bench for dvi_frame_checker with an 8x4 frame geometry.
// Latency: expected frame verdicts are queued by stimulus and checked by a monitor on each rising done.
// Backpressure: none; stimulus drives one pixel or sync cycle per clock.
module tb_dvi_frame_checker;

   typedef struct {
      logic        pass;
      logic        err_width;
      logic        err_height;
      logic [9:0]  line_count;
      logic [10:0] last_width;
      logic [15:0] err_count;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        start;
   logic [7:0]  red;
   logic [7:0]  green;
   logic [7:0]  blue;
   logic        hsync;
   logic        vsync;
   logic        busy;
   logic        done;
   logic        pass;
   logic        err_width;
   logic        err_height;
   logic [9:0]  line_count;
   logic [10:0] last_width;
   logic [15:0] err_count;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   dvi_frame_checker #(
      .WIDTH     (8),
      .HEIGHT    (4),
      .FIRST_RGB (24'h0000FF),
      .REST_RGB  (24'hFF00FF)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .hsync      (hsync),
      .vsync      (vsync),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_width  (err_width),
      .err_height (err_height),
      .line_count (line_count),
      .last_width (last_width),
      .err_count  (err_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // One clock with the given inputs; returns 1 ns after the edge.
   task automatic cyc(input logic h, input logic v, input logic [23:0] rgb, input logic st);
      hsync = h;
      vsync = v;
      {red, green, blue} = rgb;
      start = st;
      @(posedge clock);
      #1;
   endtask

   // One line: a single hsync-high cycle then npix pixels; pixel bad_idx gets red forced to 0.
   task automatic send_line(input int npix, input int bad_idx);
      logic [23:0] px;
      cyc(1'b1, 1'b0, 24'h0, 1'b0);
      for (int i = 0; i < npix; i++) begin
         px = (i == 0) ? 24'h0000FF : 24'hFF00FF;
         if (i == bad_idx) px[23:16] = 8'h00;
         cyc(1'b0, 1'b0, px, 1'b0);
      end
   endtask

   task automatic end_frame();
      cyc(1'b0, 1'b1, 24'h0, 1'b0);
      cyc(1'b0, 1'b0, 24'h0, 1'b0);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 20) begin
         cyc(1'b0, 1'b0, 24'h0, 1'b0);
         n++;
      end
      if (!done) begin
         errors++;
         $display("FAIL %s: done never rose within 20 cycles", name);
      end
   endtask

   task automatic push(input logic p, input logic ew, input logic eh,
                       input int lc, input int lw, input int ec);
      exp_t e;
      e.pass       = p;
      e.err_width  = ew;
      e.err_height = eh;
      e.line_count = 10'(lc);
      e.last_width = 11'(lw);
      e.err_count  = 16'(ec);
      exp_q.push_back(e);
   endtask

   // Monitor: each rising done pops one expected verdict and compares every field.
   initial begin
      logic done_q;
      exp_t e;
      done_q = 1'b0;
      forever begin
         @(negedge clock);
         if (!reset && done && !done_q) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: done rose with no queued expectation");
            end else begin
               e = exp_q.pop_front();
               chk("pass",       32'(pass),       32'(e.pass));
               chk("err_width",  32'(err_width),  32'(e.err_width));
               chk("err_height", 32'(err_height), 32'(e.err_height));
               chk("line_count", 32'(line_count), 32'(e.line_count));
               chk("last_width", 32'(last_width), 32'(e.last_width));
               chk("err_count",  32'(err_count),  32'(e.err_count));
            end
         end
         done_q = done;
      end
   end

   task automatic chk_cleared(input string tag);
      chk({tag, "_busy"},       32'(busy),       32'd0);
      chk({tag, "_done"},       32'(done),       32'd0);
      chk({tag, "_pass"},       32'(pass),       32'd0);
      chk({tag, "_err_width"},  32'(err_width),  32'd0);
      chk({tag, "_err_height"}, 32'(err_height), 32'd0);
      chk({tag, "_line_count"}, 32'(line_count), 32'd0);
      chk({tag, "_last_width"}, 32'(last_width), 32'd0);
      chk({tag, "_err_count"},  32'(err_count),  32'd0);
   endtask

   initial begin
      int n;
      reset = 1'b1;
      start = 1'b0;
      hsync = 1'b0;
      vsync = 1'b0;
      {red, green, blue} = 24'h0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      chk_cleared("reset");

      // Good frame.
      push(1'b1, 1'b0, 1'b0, 4, 8, 0);
      cyc(1'b0, 1'b0, 24'h0, 1'b1);
      chk("armed_busy", 32'(busy), 32'd1);
      for (int l = 0; l < 4; l++) send_line(8, -1);
      end_frame();
      wait_done("good_frame");

      // Line 2 pixel 3 has red cleared.
      push(1'b0, 1'b0, 1'b0, 4, 8, 1);
      cyc(1'b0, 1'b0, 24'h0, 1'b1);
      for (int l = 0; l < 4; l++) send_line(8, (l == 1) ? 3 : -1);
      end_frame();
      wait_done("bad_pixel");

      // Line 1 short, only three lines.
      push(1'b0, 1'b1, 1'b1, 3, 8, 0);
      cyc(1'b0, 1'b0, 24'h0, 1'b1);
      send_line(7, -1);
      send_line(8, -1);
      send_line(8, -1);
      end_frame();
      wait_done("short_frame");

      // vsync before any hsync.
      push(1'b0, 1'b0, 1'b1, 0, 0, 0);
      cyc(1'b0, 1'b0, 24'h0, 1'b1);
      end_frame();
      wait_done("zero_lines");
      cyc(1'b0, 1'b0, 24'h0, 1'b1);
      chk("rearm_done",       32'(done),       32'd0);
      chk("rearm_busy",       32'(busy),       32'd1);
      chk("rearm_err_height", 32'(err_height), 32'd0);
      chk("rearm_line_count", 32'(line_count), 32'd0);

      // Armed above: hsync and vsync rise together to end line 4.
      push(1'b1, 1'b0, 1'b0, 4, 8, 0);
      for (int l = 0; l < 4; l++) send_line(8, -1);
      cyc(1'b1, 1'b1, 24'h0, 1'b0);
      cyc(1'b0, 1'b0, 24'h0, 1'b0);
      wait_done("simul_sync");

      // Reset in the middle of line 2, then a good frame.
      cyc(1'b0, 1'b0, 24'h0, 1'b1);
      send_line(8, -1);
      send_line(3, -1);
      hsync = 1'b0;
      vsync = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      chk_cleared("mid_reset");
      push(1'b1, 1'b0, 1'b0, 4, 8, 0);
      cyc(1'b0, 1'b0, 24'h0, 1'b1);
      for (int l = 0; l < 4; l++) send_line(8, -1);
      end_frame();
      wait_done("after_reset");

      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         cyc(1'b0, 1'b0, 24'h0, 1'b0);
         n++;
      end
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected verdicts never seen", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
